// File: rtl/router_out_drain.sv
// ---------------------------------------------------------------------------
// router_out_drain
//
// Destination-side reader for one router output FIFO. It pops bytes from the
// FIFO (read data arrives one cycle after the pop), parses the
// header / payload / parity framing of each packet, and presents every byte
// to the destination port through a valid/ready output register.
//
// If the destination refuses a presented byte for TIMEOUT consecutive cycles,
// the block pulses soft_reset. That pulse flushes the FIFO, abandons the
// current packet and returns the parser to waiting for a header.
//
// Packet format:
//   header  : [7:2] payload length (0..63), [1:0] destination port
//   payload : length bytes
//   parity  : XOR of the header and all payload bytes
//
// Parameters
//   PORT_ID   output port served by this instance; compared to header[1:0]
//   TIMEOUT   consecutive stalled cycles before soft_reset is issued
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  FIFO pop request (combinational)
//   soft_reset  out  one-cycle pulse clearing the FIFO after a stall timeout
//   ready_in    in   destination accepts data_out this cycle
//   vld_out     out  data_out holds a valid byte
//   data_out    out  byte to the destination
//   pkt_done    out  pulse: parity byte has just been loaded into data_out
//   parity_err  out  pulse alongside pkt_done when the parity byte is wrong
//   addr_err    out  pulse: header port field differs from PORT_ID
// ---------------------------------------------------------------------------
module router_out_drain #(
    parameter logic [1:0] PORT_ID = 2'd0,
    parameter int         TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       soft_reset,
    input  logic       ready_in,
    output logic       vld_out,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       addr_err
);

    // The stall counter only needs to reach TIMEOUT-1.
    localparam int         TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    state_t          state;
    logic            rd_pend;    // a pop was issued last cycle; fifo_data is valid now
    logic [5:0]      len_cnt;    // payload bytes still expected
    logic [7:0]      par_acc;    // running XOR of header and payload
    logic [TO_W-1:0] to_cnt;     // consecutive stalled cycles so far
    logic            stall;

    // A presented byte that the destination is refusing.
    assign stall = vld_out & ~ready_in;

    // The timeout fires on the cycle that would be the TIMEOUT-th stall.
    // Requiring ready_in=0 (inside stall) means a byte accepted on that
    // same cycle completes normally and the timeout does not fire.
    assign soft_reset = stall & (to_cnt == TO_LAST);

    // Pop only when nothing is in flight and the output register will be
    // free at the next edge. A read in flight always lands in an empty
    // register, so captured data is never overwritten. The pop is also held
    // off while reset is asserted, so every output sits at 0 during reset.
    assign fifo_rd_en = ~reset & ~fifo_empty & ~rd_pend & ~soft_reset
                        & (~vld_out | ready_in);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_pend    <= 1'b0;
            len_cnt    <= 6'd0;
            par_acc    <= 8'd0;
            to_cnt     <= '0;
            vld_out    <= 1'b0;
            data_out   <= 8'd0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            // The status outputs are single-cycle pulses by default.
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;

            if (soft_reset) begin
                // Abandon the stalled packet. The FIFO is cleared by the same
                // pulse, so parsing restarts cleanly from the next header.
                state    <= ST_IDLE;
                rd_pend  <= 1'b0;
                len_cnt  <= 6'd0;
                par_acc  <= 8'd0;
                to_cnt   <= '0;
                vld_out  <= 1'b0;
            end else begin
                rd_pend <= fifo_rd_en;
                to_cnt  <= stall ? to_cnt + 1'b1 : '0;

                if (rd_pend) begin
                    // Capture the byte and advance the framing parser.
                    data_out <= fifo_data;
                    vld_out  <= 1'b1;

                    case (state)
                        ST_IDLE: begin
                            len_cnt  <= fifo_data[7:2];
                            par_acc  <= fifo_data;
                            addr_err <= (fifo_data[1:0] != PORT_ID);
                            // A zero-length packet goes straight to its parity byte.
                            state    <= (fifo_data[7:2] != 6'd0) ? ST_PAYLOAD : ST_PARITY;
                        end
                        ST_PAYLOAD: begin
                            par_acc <= par_acc ^ fifo_data;
                            len_cnt <= len_cnt - 6'd1;
                            if (len_cnt == 6'd1) begin
                                state <= ST_PARITY;
                            end
                        end
                        ST_PARITY: begin
                            pkt_done   <= 1'b1;
                            parity_err <= (fifo_data != par_acc);
                            state      <= ST_IDLE;
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end else if (vld_out & ready_in) begin
                    vld_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_out_drain.sv
// ---------------------------------------------------------------------------
// tb_router_out_drain
//
// Bench for router_out_drain. It models the FIFO as a queue that answers
// pops with one-cycle latency. Packets are written as whole byte lists.
// When a packet is queued, the bench walks it by the framing rules and
// records what every presented byte must look like: its value, and whether
// it must carry pkt_done, parity_err or addr_err.
//
// Outputs are sampled on the falling edge. Inputs are changed 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_router_out_drain;

    localparam int         TIMEOUT = 30;
    localparam logic [1:0] PORT_ID = 2'd0;

    logic       clock = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       soft_reset;
    logic       ready_in;
    logic       vld_out;
    logic [7:0] data_out;
    logic       pkt_done;
    logic       parity_err;
    logic       addr_err;

    always #5 clock = ~clock;

    router_out_drain #(.PORT_ID(PORT_ID), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .soft_reset (soft_reset),
        .ready_in   (ready_in),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .addr_err   (addr_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       done;
        logic       perr;
        logic       aerr;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fq[$];        // bytes held in the FIFO
    logic [7:0] stage[$];     // bytes waiting to be written into the FIFO
    logic [7:0] pkt_buf[$];   // packet under construction
    exp_t       exp_q[$];     // expected presentations, in order

    int         cyc = 0;
    int         stall_run = 0;
    int         to_count = 0;
    int         bytes_seen = 0;
    int         last_rise = 0;
    bit         prev_vld = 0;
    logic [7:0] prev_data = 8'd0;
    bit         expect_vld_low = 0;
    bit         rd_seen = 0;
    bit         sr_seen = 0;
    bit         tput_mode = 0;
    bit         tput_first = 0;
    bit         trickle = 0;
    bit         ready_rand = 0;
    bit         ready_force = 1'b0;
    int         low_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Turn pkt_buf into FIFO traffic and record the expected presentation
    // of every byte, derived only from the packet's own bytes.
    task automatic commit_pkt();
        int         n;
        logic [7:0] acc;
        exp_t       e;
        n   = pkt_buf.size();
        acc = 8'd0;
        for (int i = 0; i < n; i++) begin
            e.data = pkt_buf[i];
            e.done = 1'b0;
            e.perr = 1'b0;
            e.aerr = (i == 0) && (pkt_buf[i][1:0] != PORT_ID);
            if (i == n - 1) begin
                e.done = 1'b1;
                e.perr = (pkt_buf[i] != acc);
            end else begin
                acc = acc ^ pkt_buf[i];
            end
            exp_q.push_back(e);
            stage.push_back(pkt_buf[i]);
        end
    endtask

    task automatic build_random_pkt();
        int         len;
        logic [5:0] l6;
        logic [1:0] prt;
        logic [7:0] par;
        logic [7:0] b;
        len = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 8);
        l6  = 6'(len);
        prt = 2'($urandom_range(0, 3));
        pkt_buf.delete();
        pkt_buf.push_back({l6, prt});
        par = {l6, prt};
        for (int i = 0; i < len; i++) begin
            b   = 8'($urandom_range(0, 255));
            par = par ^ b;
            pkt_buf.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) begin
            par = par ^ 8'($urandom_range(1, 255));
        end
        pkt_buf.push_back(par);
    endtask

    // One clock cycle: check the outputs on the falling edge, then act as
    // the FIFO and the destination just after the rising edge.
    task automatic step();
        bit   exp_sr;
        exp_t e;
        @(negedge clock);
        chk("rd_when_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        if (vld_out && !ready_in) begin
            chk("rd_while_stall", 32'(fifo_rd_en), 32'd0);
        end
        stall_run = (vld_out && !ready_in) ? stall_run + 1 : 0;
        exp_sr    = (stall_run == TIMEOUT);
        chk("soft_reset", 32'(soft_reset), 32'(exp_sr));
        if (expect_vld_low) begin
            chk("vld_after_timeout", 32'(vld_out), 32'd0);
            expect_vld_low = 0;
        end
        if (vld_out && !prev_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                $display("byte %0d data=%02h done=%0d perr=%0d aerr=%0d",
                         bytes_seen, data_out, pkt_done, parity_err, addr_err);
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("pkt_done", 32'(pkt_done), 32'(e.done));
                chk("parity_err", 32'(parity_err), 32'(e.perr));
                chk("addr_err", 32'(addr_err), 32'(e.aerr));
                if (tput_mode && !tput_first) begin
                    chk("byte_gap", 32'(cyc - last_rise), 32'd2);
                end
                tput_first = 0;
                last_rise  = cyc;
                bytes_seen++;
            end
        end else begin
            chk("pulse_idle", 32'({pkt_done, parity_err, addr_err}), 32'd0);
            if (vld_out && prev_vld) begin
                chk("data_hold", 32'(data_out), 32'(prev_data));
            end
        end
        if (exp_sr) begin
            exp_q.delete();
            stall_run      = 0;
            expect_vld_low = 1;
            to_count++;
        end
        sr_seen   = soft_reset;
        rd_seen   = fifo_rd_en;
        prev_vld  = vld_out;
        prev_data = data_out;

        @(posedge clock);
        #1;
        if (sr_seen) begin
            fq.delete();
            stage.delete();
        end else if (rd_seen && fq.size() > 0) begin
            fifo_data = fq.pop_front();
        end
        if (stage.size() > 0 && (!trickle || $urandom_range(0, 2) == 0)) begin
            if (trickle) begin
                fq.push_back(stage.pop_front());
            end else begin
                while (stage.size() > 0) fq.push_back(stage.pop_front());
            end
        end
        fifo_empty = (fq.size() == 0);
        if (ready_rand) begin
            if (low_run >= 12) ready_in = 1'b1;
            else ready_in = ($urandom_range(0, 2) != 0);
            low_run = ready_in ? 0 : low_run + 1;
        end else begin
            ready_in = ready_force;
        end
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || stage.size() != 0 || fq.size() != 0 || vld_out)
               && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (bytes_seen < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(bytes_seen >= target), 32'd1);
    endtask

    task automatic reset_outs(input string tag);
        chk(tag, 32'({vld_out, data_out, pkt_done, parity_err, addr_err,
                      soft_reset, fifo_rd_en}), 32'd0);
    endtask

    initial begin
        int b0;
        int t0;
        int n;

        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 8'd0;
        ready_in   = 1'b0;
        #1;
        reset_outs("reset_state");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // T1: one byte every two cycles with the destination always ready.
        // The parity byte is 09^AA^BB = 18.
        ready_force = 1'b1;
        tput_mode   = 1;
        tput_first  = 1;
        pkt_buf     = '{8'h09, 8'hAA, 8'hBB, 8'h18};
        commit_pkt();
        drain("t1_drain", 100);
        tput_mode = 0;

        // T2: ten stalled cycles on the header; the byte must hold and no
        // pop or timeout may happen.
        ready_force = 1'b0;
        b0 = bytes_seen;
        t0 = to_count;
        pkt_buf = '{8'h09, 8'hAA, 8'hBB, 8'h18};
        commit_pkt();
        wait_bytes("t2_first", b0 + 1, 50);
        repeat (9) step();
        ready_force = 1'b1;
        drain("t2_drain", 100);
        chk("t2_no_timeout", 32'(to_count), 32'(t0));

        // T4: zero-length packet.
        pkt_buf = '{8'h00, 8'h00};
        commit_pkt();
        drain("t4_drain", 100);

        // T5: bad parity, then a header addressed to another port.
        pkt_buf = '{8'h09, 8'hAA, 8'hBB, 8'hFF};
        commit_pkt();
        pkt_buf = '{8'h0A, 8'h11, 8'h22, 8'h39};
        commit_pkt();
        drain("t5_drain", 200);

        // T3: the destination never accepts, so soft_reset must fire on
        // stall cycle TIMEOUT and the packet is discarded.
        ready_force = 1'b0;
        t0 = to_count;
        pkt_buf = '{8'h05, 8'h33, 8'h36};
        commit_pkt();
        n = 0;
        while (to_count == t0 && n < 100) begin
            step();
            n++;
        end
        chk("t3_timeout_seen", 32'(to_count), 32'(t0 + 1));
        step();
        ready_force = 1'b1;
        pkt_buf = '{8'h04, 8'h5A, 8'h5E};
        commit_pkt();
        drain("t3_after", 100);

        // T6: asynchronous reset in the middle of a ten-byte packet.
        b0 = bytes_seen;
        pkt_buf.delete();
        pkt_buf.push_back(8'h20);
        for (int i = 0; i < 8; i++) pkt_buf.push_back(8'($urandom_range(0, 255)));
        pkt_buf.push_back(8'h00);
        commit_pkt();
        wait_bytes("t6_partial", b0 + 3, 50);
        #2;
        reset = 1'b1;
        fq.delete();
        stage.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        #1;
        reset_outs("t6_async_reset");
        @(posedge clock);
        #1;
        reset_outs("t6_reset_held");
        @(negedge clock);
        reset     = 1'b0;
        prev_vld  = 0;
        stall_run = 0;
        @(posedge clock);
        #1;
        pkt_buf = '{8'h08, 8'h01, 8'h02, 8'h0B};
        commit_pkt();
        drain("t6_after", 100);

        // Random traffic: random packets, random destination back-pressure
        // that stays below the timeout, and a FIFO that sometimes runs dry
        // in the middle of a packet.
        ready_rand = 1;
        for (int p = 0; p < 30; p++) begin
            trickle = ($urandom_range(0, 2) == 0);
            build_random_pkt();
            commit_pkt();
            repeat ($urandom_range(0, 6)) step();
        end
        trickle = 0;
        drain("rand_drain", 20000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
